// File: rtl/data_mem_resp.sv
// Data-memory responder: byte/half/word stores and sign/zero-extended loads with WAIT_STATES wait cycles.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses raise err instead of being force-aligned.
module data_mem_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  sel_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q;
    logic [2:0]     sel_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mem_rd_q;
    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic [AW-1:0]  rd_idx, wr_idx;
    logic           is_b, is_h, illegal, fault;
    logic [1:0]     off;
    logic [3:0]     be;
    logic           do_write, do_load;
    logic [7:0]     rd_bytes [4];
    logic [7:0]     wr_lane [4];
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_val;
    logic           unused_addr_hi;

    assign accept = (state_q == S_IDLE) && req;
    // Bits above the word index only alias the array.
    assign unused_addr_hi = ^addr[31:AW+2];

    // Request capture; the latched copy drives the whole transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            sel_q   <= sel_type;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Access decode on the latched request.
    always_comb begin
        is_b    = (sel_q[1:0] == 2'b00);
        is_h    = (sel_q[1:0] == 2'b01);
        illegal = (sel_q == 3'b011) || (sel_q[2:1] == 2'b11) || (sel_q[2] && we_q);
`ifdef MISALIGN_TRAP_EN
        off   = addr_q[1:0];
        fault = illegal || (is_h && addr_q[0]) ||
                (!is_b && !is_h && (addr_q[1:0] != 2'b00));
`else
        off   = is_b ? addr_q[1:0] : (is_h ? {addr_q[1], 1'b0} : 2'b00);
        fault = illegal;
`endif
        if (is_b) begin
            be = 4'b0001 << off;
        end else if (is_h) begin
            be = 4'b0011 << off;
        end else begin
            be = 4'b1111;
        end
    end

    assign do_write = (state_q == S_DONE) && we_q && !fault;
    assign do_load  = (state_q == S_DONE) && !we_q && !fault;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_bytes[gi] = mem_rd_q[gi*8 +: 8];
            // Narrow stores replicate their data so any enabled lane sees the right byte.
            assign wr_lane[gi]  = is_b ? wdata_q[7:0] :
                                  (is_h ? wdata_q[(gi%2)*8 +: 8] : wdata_q[gi*8 +: 8]);
        end
    endgenerate

    // The read address is taken from the bus in IDLE so a zero-wait access has its word ready in DONE.
    assign rd_idx = (state_q == S_IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];
    assign wr_idx = addr_q[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_lane[i];
                end
            end
        end
        mem_rd_q <= mem[rd_idx];
    end

    always_comb begin
        byte_sel = rd_bytes[off];
        half_sel = off[1] ? mem_rd_q[31:16] : mem_rd_q[15:0];
        case (sel_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = mem_rd_q;
        endcase
    end

    assign rdata_d = do_load ? load_val : rdata_q;
    assign rdata   = rdata_d;
    assign ready   = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);
    assign err     = (state_q == S_DONE) && fault;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with 1 wait state, one with 3 (reset-abort scenario).
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst1, rst3, req1, req3, we;
    logic [2:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, busy1, busy3, err1, err3;
    int          checks = 0;
    int          failures = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        w;
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] x;
        logic        e;
    } vec_t;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH(1024), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst1), .req(req1), .we(we), .sel_type(sel), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1));

    data_mem_resp #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we), .sel_type(sel), .addr(addr),
        .wdata(wdata), .rdata(rdata3), .ready(ready3), .busy(busy3), .err(err3));

    // Issues one request, scrambles the bus while busy, and reports what came back.
    task automatic do_access(input bit use3, input logic w, input logic [2:0] s,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er,
                             output int lat, output int nbusy, output logic tail);
        bit got;
        got = 1'b0;
        lat = 0; nbusy = 0; rd = '0; er = 1'b0; tail = 1'b1;
        @(negedge clk);
        we = w; sel = s; addr = a; wdata = d;
        if (use3) req3 = 1'b1; else req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; req3 = 1'b0;
        we = ~w; sel = 3'b111; addr = ~a; wdata = ~d;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (use3 ? busy3 : busy1) nbusy++;
            if (use3 ? ready3 : ready1) begin
                got = 1'b1;
                lat = i;
                rd  = use3 ? rdata3 : rdata1;
                er  = use3 ? err3 : err1;
            end else begin
                @(negedge clk);
            end
        end
        if (got) begin
            @(negedge clk);
            tail = use3 ? (busy3 | ready3 | err3) : (busy1 | ready1 | err1);
        end
        $display("access dut%0d we=%0b sel=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 use3 ? 3 : 1, w, s, a, d, rd, er, lat);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy1); end
        checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err1); end
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata1); end
        checks++; if (busy3 !== 1'b0 || ready3 !== 1'b0) begin failures++; $display("FAIL reset_dut3 busy=%b ready=%b want=0", busy3, ready3); end
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        vec_t v [2] = '{
            '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0},
            '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL word[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL word[%0d] err got=%b want=%b", i, er, v[i].e); end
            checks++; if (lat != 2) begin failures++; $display("FAIL word[%0d] latency got=%0d want=2", i, lat); end
            checks++; if (nb != 2) begin failures++; $display("FAIL word[%0d] busy_cycles got=%0d want=2", i, nb); end
            checks++; if (tl !== 1'b0) begin failures++; $display("FAIL word[%0d] idle_after got=%b want=0", i, tl); end
        end
    endtask

    task automatic test_bytes();
        vec_t v [7] = '{
            '{1'b1, 3'b000, 32'h11, 32'hAAAAAA7F, 32'hDEADBEEF, 1'b0},
            '{1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0},
            '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0},
            '{1'b1, 3'b000, 32'h13, 32'h12345680, 32'hDEAD7FEF, 1'b0},
            '{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0},
            '{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0},
            '{1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL bytes[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL bytes[%0d] err got=%b want=%b", i, er, v[i].e); end
            checks++; if (lat != 2) begin failures++; $display("FAIL bytes[%0d] latency got=%0d want=2", i, lat); end
        end
    endtask

    task automatic test_half();
        vec_t v [6] = '{
            '{1'b1, 3'b010, 32'h20, 32'h13572468, 32'hFFFFFFAD, 1'b0},
            '{1'b1, 3'b001, 32'h22, 32'h55558001, 32'hFFFFFFAD, 1'b0},
            '{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0},
            '{1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0},
            '{1'b0, 3'b010, 32'h20, 32'h0, 32'h80012468, 1'b0},
            '{1'b0, 3'b001, 32'h20, 32'h0, 32'h00002468, 1'b0}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL half[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL half[%0d] err got=%b want=%b", i, er, v[i].e); end
        end
    endtask

    task automatic test_wrap();
        vec_t v [4] = '{
            '{1'b0, 3'b010, 32'h00001010, 32'h0, 32'h80AD7FEF, 1'b0},
            '{1'b1, 3'b010, 32'hFFFFF040, 32'hCAFEBABE, 32'h80AD7FEF, 1'b0},
            '{1'b0, 3'b010, 32'h00000040, 32'h0, 32'hCAFEBABE, 1'b0},
            '{1'b0, 3'b101, 32'h00001042, 32'h0, 32'h0000CAFE, 1'b0}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL wrap[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL wrap[%0d] err got=%b want=%b", i, er, v[i].e); end
        end
    endtask

    task automatic test_misalign();
        vec_t v [4] = '{
            '{1'b0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0000CAFE : 32'h80AD7FEF, TRAP},
            '{1'b1, 3'b001, 32'h21, 32'h0000BEEF, TRAP ? 32'h0000CAFE : 32'h80AD7FEF, TRAP},
            '{1'b0, 3'b010, 32'h20, 32'h0, TRAP ? 32'h80012468 : 32'h8001BEEF, 1'b0},
            '{1'b0, 3'b001, 32'h23, 32'h0, TRAP ? 32'h80012468 : 32'hFFFF8001, TRAP}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL misalign[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL misalign[%0d] err got=%b want=%b", i, er, v[i].e); end
            checks++; if (lat != 2) begin failures++; $display("FAIL misalign[%0d] latency got=%0d want=2", i, lat); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] p = TRAP ? 32'h80012468 : 32'hFFFF8001;
        vec_t v [5] = '{
            '{1'b1, 3'b111, 32'h20, 32'hFFFFFFFF, p, 1'b1},
            '{1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, p, 1'b1},
            '{1'b0, 3'b011, 32'h20, 32'h0, p, 1'b1},
            '{1'b0, 3'b110, 32'h20, 32'h0, p, 1'b1},
            '{1'b0, 3'b010, 32'h20, 32'h0, TRAP ? 32'h80012468 : 32'h8001BEEF, 1'b0}};
        logic [31:0] rd; logic er, tl; int lat, nb;
        foreach (v[i]) begin
            do_access(1'b0, v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, nb, tl);
            checks++; if (rd !== v[i].x) begin failures++; $display("FAIL illegal[%0d] rdata got=%h want=%h", i, rd, v[i].x); end
            checks++; if (er !== v[i].e) begin failures++; $display("FAIL illegal[%0d] err got=%b want=%b", i, er, v[i].e); end
            checks++; if (tl !== 1'b0) begin failures++; $display("FAIL illegal[%0d] err_pulse_len got=%b want=0", i, tl); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] pattern;
        pattern = '0;
        @(negedge clk);
        we = 1'b0; sel = 3'b010; addr = 32'h40; wdata = 32'h0; req1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pattern[i] = ready1;
        end
        req1 = 1'b0;
        $display("back_to_back ready pattern=%b rdata=%h", pattern, rdata1);
        checks++; if (pattern !== 9'b010010010) begin failures++; $display("FAIL b2b_ready_pattern got=%b want=010010010", pattern); end
        checks++; if (rdata1 !== 32'hCAFEBABE) begin failures++; $display("FAIL b2b_rdata got=%h want=cafebabe", rdata1); end
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b want=0", busy1); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, tl; int lat, nb; int stray;
        do_access(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, rd, er, lat, nb, tl);
        checks++; if (lat != 4) begin failures++; $display("FAIL abort_ws3_latency got=%0d want=4", lat); end
        checks++; if (nb != 4) begin failures++; $display("FAIL abort_ws3_busy got=%0d want=4", nb); end
        @(negedge clk);
        we = 1'b1; sel = 3'b010; addr = 32'h30; wdata = 32'h12345678; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        $display("abort dut3 after reset busy=%b ready=%b", busy3, ready3);
        checks++; if (busy3 !== 1'b0 || ready3 !== 1'b0) begin failures++; $display("FAIL abort_state busy=%b ready=%b want=0", busy3, ready3); end
        rst3 = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready3) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL abort_stray_ready got=%0d want=0", stray); end
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat, nb, tl);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL abort_no_write got=%h want=cafef00d", rd); end
        checks++; if (lat != 4) begin failures++; $display("FAIL abort_load_latency got=%0d want=4", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, tl; int lat, nb;
        @(negedge clk);
        we = 1'b1; sel = 3'b010; addr = 32'h40; wdata = 32'h0; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        $display("reset_mid busy=%b ready=%b rdata=%h", busy1, ready1, rdata1);
        checks++; if (busy1 !== 1'b0 || ready1 !== 1'b0) begin failures++; $display("FAIL reset_mid_state busy=%b ready=%b want=0", busy1, ready1); end
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_mid_rdata got=%h want=0", rdata1); end
        rst1 = 1'b1;
        do_access(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, nb, tl);
        checks++; if (rd !== 32'hCAFEBABE) begin failures++; $display("FAIL reset_mid_no_write got=%h want=cafebabe", rd); end
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; sel = 3'b000; addr = '0; wdata = '0;
        test_reset();
        test_word();
        test_bytes();
        test_half();
        test_wrap();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
